// File: rtl/simon_sequencer.sv
// Simon-style sequencer: plays an LFSR-derived colour sequence and checks the player's echo.
// Define SEQ_TIMEOUT_EN to fail a round when WAIT_IN sees no press for TIMEOUT_CYCLES.
module simon_sequencer #(
  parameter int MAX_LEVEL      = 16,
  parameter int SHOW_CYCLES    = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic [3:0] lfsr_val,
  output logic       lfsr_step,
  output logic       lfsr_rerun,
  output logic       lfsr_randomize,
  output logic [3:0] led,
  output logic [4:0] level,
  output logic       busy,
  output logic       fail,
  output logic       win
);

  localparam int SG_MAX  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SG_MAX) ? TIMEOUT_CYCLES : SG_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_PRE   = CW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam logic [4:0]    LEVEL_MAX = 5'(MAX_LEVEL);
`ifdef SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [3:0] {
    IDLE, SEED, REWIND, SETTLE, SHOW_ON, SHOW_GAP,
    WAIT_IN, STEP_IN, ROUND_UP, FAIL, WIN
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    idx_q;
  logic [4:0]    level_q;
  logic [3:0]    led_q;
  logic          step_q;
  logic          rerun_q;
  logic          busy_q;
  logic          fail_q;
  logic          win_q;
  logic          ret_in_q;

  logic       more_elems;
  logic [3:0] colour_led;
  logic       unused_lfsr_hi;

  assign more_elems     = (idx_q + 5'd1) < level_q;
  assign colour_led     = 4'b0001 << lfsr_val[1:0];
  assign unused_lfsr_hi = ^lfsr_val[3:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      level_q  <= 5'd1;
      led_q    <= '0;
      step_q   <= 1'b0;
      rerun_q  <= 1'b0;
      busy_q   <= 1'b0;
      fail_q   <= 1'b0;
      win_q    <= 1'b0;
      ret_in_q <= 1'b0;
    end else begin
      step_q  <= 1'b0;
      rerun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SEED;
            busy_q  <= 1'b1;
          end
        end
        SEED: begin
          if (!start) begin
            state_q  <= REWIND;
            level_q  <= 5'd1;
            idx_q    <= '0;
            rerun_q  <= 1'b1;
            ret_in_q <= 1'b0;
          end
        end
        REWIND: begin
          state_q <= SETTLE;
          idx_q   <= '0;
          cnt_q   <= '0;
        end
        SETTLE: begin
          if (cnt_q == CNT_ONE) begin
            cnt_q <= '0;
            if (ret_in_q) begin
              state_q <= WAIT_IN;
            end else begin
              state_q <= SHOW_ON;
              led_q   <= colour_led;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        SHOW_ON: begin
          if (cnt_q == SHOW_LAST) begin
            state_q <= SHOW_GAP;
            led_q   <= '0;
            cnt_q   <= '0;
            step_q  <= (GAP_CYCLES == 1) && more_elems;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        SHOW_GAP: begin
          // The step pulse occupies the final dark cycle so SETTLE still spans 2 cycles after it.
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (more_elems) begin
              state_q  <= SETTLE;
              idx_q    <= idx_q + 5'd1;
              ret_in_q <= 1'b0;
            end else begin
              state_q  <= REWIND;
              rerun_q  <= 1'b1;
              idx_q    <= '0;
              ret_in_q <= 1'b1;
            end
          end else begin
            cnt_q  <= cnt_q + CNT_ONE;
            step_q <= (GAP_CYCLES > 1) && (cnt_q == GAP_PRE) && more_elems;
          end
        end
        WAIT_IN: begin
          if (btn != 4'b0000) begin
            cnt_q <= '0;
            if (btn == colour_led) begin
              state_q <= STEP_IN;
              led_q   <= btn;
              step_q  <= more_elems;
            end else begin
              state_q <= FAIL;
              led_q   <= 4'hF;
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (cnt_q == TMO_LAST) begin
            cnt_q   <= '0;
            state_q <= FAIL;
            led_q   <= 4'hF;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
`endif
        end
        STEP_IN: begin
          led_q <= '0;
          cnt_q <= '0;
          if (more_elems) begin
            state_q  <= SETTLE;
            idx_q    <= idx_q + 5'd1;
            ret_in_q <= 1'b1;
          end else begin
            state_q <= ROUND_UP;
          end
        end
        ROUND_UP: begin
          if (level_q == LEVEL_MAX) begin
            state_q <= WIN;
            win_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q  <= REWIND;
            level_q  <= level_q + 5'd1;
            rerun_q  <= 1'b1;
            idx_q    <= '0;
            ret_in_q <= 1'b0;
          end
        end
        FAIL, WIN: begin
          if (start) begin
            state_q <= SEED;
            fail_q  <= 1'b0;
            win_q   <= 1'b0;
            busy_q  <= 1'b1;
            led_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lfsr_step      = step_q;
  assign lfsr_rerun     = rerun_q;
  assign lfsr_randomize = !reset && start && ((state_q == IDLE) || (state_q == SEED));
  assign led            = led_q;
  assign level          = level_q;
  assign busy           = busy_q;
  assign fail           = fail_q;
  assign win            = win_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: LFSR stand-in with 2-cycle latency, timeline model of playback.
module tb_simon_sequencer;
  localparam int ML   = 2;
  localparam int SHOW = 8;
  localparam int GAP  = 4;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] lfsr_val = 4'h0;
  logic       lfsr_step, lfsr_rerun, lfsr_randomize;
  logic [3:0] led;
  logic [4:0] level;
  logic       busy, fail, win;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] seq [32];
  int         ptr = 0;
  int         p_nxt;
  logic [3:0] s1 = 4'h0;

  always #5 clk = ~clk;

  simon_sequencer #(.MAX_LEVEL(ML), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .btn(btn), .lfsr_val(lfsr_val),
    .lfsr_step(lfsr_step), .lfsr_rerun(lfsr_rerun), .lfsr_randomize(lfsr_randomize),
    .led(led), .level(level), .busy(busy), .fail(fail), .win(win)
  );

  // Stand-in LFSR: element pointer into seq[], output appears two cycles after a pulse.
  always_comb p_nxt = lfsr_rerun ? 0 : (lfsr_step ? ptr + 1 : ptr);
  always @(posedge clk) begin
    ptr      <= p_nxt;
    s1       <= seq[p_nxt[4:0]];
    lfsr_val <= s1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk)
    if (!reset) chk("ctl_onehot", ($countones({lfsr_step, lfsr_rerun, lfsr_randomize}) <= 1), 1);

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_level"}, level, 1);
    chk({tag, "_flags"}, {busy, fail, win}, 0);
    chk({tag, "_ctl"}, {lfsr_step, lfsr_rerun, lfsr_randomize}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; btn = '0;
    cyc(); cyc();
    check_reset_state("reset");
    reset = 1'b0;
  endtask

  task automatic seed(input bit from_idle, input int nhigh);
    start = 1'b1;
    #1;
    if (from_idle) chk("rand_first", lfsr_randomize, 1);
    for (int k = 1; k < nhigh; k++) begin
      cyc();
      chk("rand_held", lfsr_randomize, 1);
      chk("seed_busy", busy, 1);
      chk("seed_flags", {fail, win}, 0);
    end
    cyc();
    start = 1'b0;
    #1;
    chk("rand_drop", lfsr_randomize, 0);
  endtask

  // Waits for the rerun that opens a round, then compares every cycle of playback
  // (plus the closing rerun and settle) against a timeline built from the game rules.
  task automatic trace(input int L, input bit garbage, output int waited);
    logic [3:0] e_led [$];
    bit         e_st [$];
    bit         e_rr [$];
    int         bad;
    logic [3:0] g_led;
    logic       g_st, g_rr, g_busy;
    logic [4:0] g_lvl;
    waited = 0;
    do begin cyc(); waited++; end while (!lfsr_rerun && waited < 50);
    if (!lfsr_rerun) begin
      n_chk++; n_fail++;
      $display("FAIL rerun_wait: no rerun pulse within %0d cycles at level %0d", waited, L);
      return;
    end
    e_led.push_back(4'h0); e_st.push_back(1'b0); e_rr.push_back(1'b1);
    repeat (2) begin e_led.push_back(4'h0); e_st.push_back(1'b0); e_rr.push_back(1'b0); end
    for (int i = 0; i < L; i++) begin
      repeat (SHOW) begin e_led.push_back(4'b0001 << seq[i][1:0]); e_st.push_back(1'b0); e_rr.push_back(1'b0); end
      for (int g = 0; g < GAP; g++) begin
        e_led.push_back(4'h0); e_st.push_back((g == GAP - 1) && (i < L - 1)); e_rr.push_back(1'b0);
      end
      if (i < L - 1)
        repeat (2) begin e_led.push_back(4'h0); e_st.push_back(1'b0); e_rr.push_back(1'b0); end
    end
    e_led.push_back(4'h0); e_st.push_back(1'b0); e_rr.push_back(1'b1);
    repeat (2) begin e_led.push_back(4'h0); e_st.push_back(1'b0); e_rr.push_back(1'b0); end
    bad = -1;
    g_led = '0; g_st = 1'b0; g_rr = 1'b0; g_busy = 1'b0; g_lvl = '0;
    for (int k = 0; k < e_led.size(); k++) begin
      if (k > 0) begin
        if (garbage) btn = 4'($urandom);
        cyc();
      end
      if (bad < 0 && (led !== e_led[k] || lfsr_step !== e_st[k] || lfsr_rerun !== e_rr[k] ||
                      busy !== 1'b1 || level !== 5'(L))) begin
        bad = k; g_led = led; g_st = lfsr_step; g_rr = lfsr_rerun; g_busy = busy; g_lvl = level;
      end
    end
    btn = '0;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL playback L%0d cycle %0d: led=%b step=%b rerun=%b busy=%b level=%0d, expected led=%b step=%b rerun=%b busy=1 level=%0d",
               L, bad, g_led, g_st, g_rr, g_busy, g_lvl, e_led[bad], e_st[bad], e_rr[bad], L);
    end
  endtask

  task automatic press(input logic [3:0] b, input bit last, input bit ok);
    btn = b;
    cyc();
    btn = '0;
    if (ok) begin
      chk("echo_led", led, b);
      chk("echo_step", lfsr_step, !last);
      chk("echo_fail", fail, 0);
      if (!last) begin cyc(); cyc(); cyc(); end
    end else begin
      chk("fail_flag", fail, 1);
      chk("fail_led", led, 4'hF);
      chk("fail_busy", busy, 0);
    end
  endtask

  task automatic play_game(input bit from_idle, input int nhigh, input int fail_lvl,
                           input int fail_idx, input logic [3:0] bad_btn, input bit garbage);
    int w;
    seed(from_idle, nhigh);
    for (int L = 1; L <= ML; L++) begin
      trace(L, garbage, w);
      chk("rerun_latency", w, (L == 1) ? 1 : 2);
      cyc();
      for (int i = 0; i < L; i++) begin
        repeat ($urandom_range(0, 3)) cyc();
        if (L == fail_lvl && i == fail_idx) begin
          press(bad_btn, 1'b0, 1'b0);
          return;
        end
        press(4'b0001 << seq[i][1:0], i == L - 1, 1'b1);
      end
    end
    cyc(); cyc();
    chk("win_flag", win, 1);
    chk("win_busy", busy, 0);
    chk("win_led", led, 0);
  endtask

  typedef struct {
    logic [1:0] col;
    logic [3:0] b;
    logic       exp_fail;
    logic [3:0] exp_led;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int w, fl, fi, bad;
    bit idle;
    logic [3:0] bb, c;

    tbl[0] = '{2'd0, 4'b0001, 1'b0, 4'b0001};
    tbl[1] = '{2'd1, 4'b0010, 1'b0, 4'b0010};
    tbl[2] = '{2'd2, 4'b0001, 1'b1, 4'hF};
    tbl[3] = '{2'd3, 4'b1000, 1'b0, 4'b1000};
    tbl[4] = '{2'd0, 4'b0011, 1'b1, 4'hF};
    tbl[5] = '{2'd3, 4'b1111, 1'b1, 4'hF};
    tbl[6] = '{2'd2, 4'b0100, 1'b0, 4'b0100};
    tbl[7] = '{2'd1, 4'b1010, 1'b1, 4'hF};
    for (int i = 0; i < 32; i++) seq[i] = 4'($urandom);

    // Directed: colour 2 then 3; wrong second press in round 2.
    do_reset();
    seq[0] = 4'h2; seq[1] = 4'h3;
    play_game(1'b1, 5, 2, 1, 4'b0001, 1'b0);
    // Restart from FAIL and win, then re-seed out of WIN.
    play_game(1'b0, 3, 0, 0, 4'h0, 1'b0);
    start = 1'b1;
    cyc();
    chk("reseed_win_clear", win, 0);
    chk("reseed_busy", busy, 1);
    chk("reseed_rand", lfsr_randomize, 1);
    start = 1'b0;

    // Table: one press at level 1 against each colour.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < 32; i++) seq[i] = 4'($urandom);
      seq[0] = {2'($urandom), tbl[v].col};
      seed(1'b1, 2);
      trace(1, 1'b0, w);
      cyc();
      btn = tbl[v].b;
      cyc();
      btn = '0;
      chk("tbl_led", led, tbl[v].exp_led);
      chk("tbl_fail", fail, tbl[v].exp_fail);
      chk("tbl_busy", busy, !tbl[v].exp_fail);
    end

    // Reset in the middle of playback.
    do_reset();
    seed(1'b1, 3);
    repeat (8) cyc();
    chk("pre_reset_lit", led != 4'h0, 1);
    reset = 1'b1;
    cyc();
    check_reset_state("midreset");
    reset = 1'b0;
    bad = 0;
    repeat (30) begin
      cyc();
      if (lfsr_step || lfsr_rerun || busy) bad = 1;
    end
    chk("post_reset_quiet", bad, 0);

    // Randomized games with random failures and ignored button noise.
    do_reset();
    idle = 1'b1;
    for (int g = 0; g < 24; g++) begin
      for (int i = 0; i < 32; i++) seq[i] = 4'($urandom);
      fl = $urandom_range(0, ML);
      fi = (fl > 0) ? $urandom_range(0, fl - 1) : 0;
      bb = 4'h0;
      if (fl > 0) begin
        c = 4'b0001 << seq[fi][1:0];
        do bb = 4'($urandom_range(1, 15)); while (bb == c);
      end
      play_game(idle, idle ? $urandom_range(1, 5) : $urandom_range(2, 5), fl, fi, bb, 1'b1);
      idle = 1'b0;
    end

    // Input timeout.
    do_reset();
    for (int i = 0; i < 32; i++) seq[i] = 4'($urandom);
    seed(1'b1, 2);
    trace(1, 1'b0, w);
`ifdef SEQ_TIMEOUT_EN
    repeat (TMO) cyc();
    chk("tmo_not_yet", fail, 0);
    cyc();
    chk("tmo_fail", fail, 1);
    chk("tmo_led", led, 4'hF);
    chk("tmo_busy", busy, 0);
`else
    repeat (10000) cyc();
    chk("no_tmo_busy", busy, 1);
    chk("no_tmo_fail", fail, 0);
    press(4'b0001 << seq[0][1:0], 1'b1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 Parameters: MAX_LEVEL, default 16, rounds needed to win (range 1..31).
REQ-002 Parameters: SHOW_CYCLES, default 8, cycles each colour is lit during playback (>=1).
REQ-003 Parameters: GAP_CYCLES, default 4, dark cycles between playback colours (>=1).
REQ-004 Parameters: TIMEOUT_CYCLES, default 1024, input timeout length (used only under SEQ_TIMEOUT_EN).
REQ-005 Port: clk  input  1  clock; all logic on rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: start  input  1  level; held high to seed, falling edge begins game.
REQ-008 Port: btn  input  4  player buttons, one-hot pulses, one cycle each.
REQ-009 Port: lfsr_val  input  4  registered LFSR nibble; valid 2 cycles after any step/rerun pulse.
REQ-010 Port: lfsr_step, lfsr_rerun, lfsr_randomize  output  1 each  LFSR controls.
REQ-011 Port: led  output  4  one-hot playback/echo display.
REQ-012 Port: level  output  5  current round, 1..MAX_LEVEL.
REQ-013 Port: busy, fail, win  output  1 each  status flags.

Function
REQ-014 Colour of a sequence element SHALL be lfsr_val[1:0]; led SHALL show 1<<colour.
REQ-015 States: IDLE, SEED, REWIND, SETTLE, SHOW_ON, SHOW_GAP, WAIT_IN, STEP_IN, ROUND_UP, FAIL, WIN.
REQ-016 IDLE: start high -> SEED; lfsr_randomize SHALL equal start while in IDLE/SEED.
REQ-017 SEED: start low -> REWIND with level=1; randomize deasserts the same cycle start falls.
REQ-018 REWIND: lfsr_rerun high exactly 1 cycle, element index idx cleared, then SETTLE.
REQ-019 SETTLE: 2-cycle wait after every rerun/step pulse before lfsr_val is sampled; returns to the calling phase (playback or input).
REQ-020 Playback: SHOW_ON drives led for SHOW_CYCLES, then SHOW_GAP dark for GAP_CYCLES; at gap end, if idx+1<level, pulse lfsr_step 1 cycle, idx+=1, SETTLE, SHOW_ON; else REWIND then WAIT_IN with idx=0.
REQ-021 WAIT_IN: btn==0 holds; btn one-hot matching colour -> STEP_IN; any other non-zero btn (wrong or multi-hot) -> FAIL.
REQ-022 STEP_IN: led echoes pressed button 1 cycle; if idx+1==level -> ROUND_UP, else lfsr_step pulse, idx+=1, SETTLE, WAIT_IN.
REQ-023 ROUND_UP: level==MAX_LEVEL -> WIN; else level+=1, REWIND, playback.
REQ-024 btn pulses outside WAIT_IN SHALL be ignored.
REQ-025 FAIL/WIN: sticky flag high, led=4'hF for FAIL, led=0 for WIN; start high -> SEED clearing flags.
REQ-026 busy SHALL be high in every state except IDLE, FAIL, WIN.
REQ-027 Never more than one of lfsr_step/lfsr_rerun/lfsr_randomize high in a cycle.
REQ-028 Cycle counters SHALL be sized for max(SHOW_CYCLES,GAP_CYCLES,TIMEOUT_CYCLES) with no wrap.

Reset
REQ-029 reset SHALL force IDLE; led=0, level=1, idx=0, busy=fail=win=0, all LFSR controls 0.
REQ-030 reset mid-game SHALL abort within the same edge; no LFSR pulse SHALL follow it.

Configuration
REQ-031 Macro SEQ_TIMEOUT_EN defined: WAIT_IN lasting TIMEOUT_CYCLES without a press -> FAIL; counter restarts on each WAIT_IN entry.
REQ-032 SEQ_TIMEOUT_EN undefined: WAIT_IN waits indefinitely; timeout counter absent.

Verification
REQ-033 Reset, start high 5 cycles then low -> randomize high 5 cycles, rerun pulse 1 cycle later, level=1, busy=1.
REQ-034 lfsr_val=4'h2 during level 1 -> led=4'b0100 for exactly SHOW_CYCLES=8 cycles, 4 dark, then rerun, WAIT_IN.
REQ-035 Level 1, btn=4'b0100 -> ROUND_UP, level=2, playback shows 2 colours with one lfsr_step between.
REQ-036 Level 2, second press wrong (btn=4'b0001 vs colour 3) -> fail=1, led=4'hF, busy=0 next cycle.
REQ-037 MAX_LEVEL=2, correct input for both rounds -> win=1, busy=0; start then re-seeds and clears win.
REQ-038 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no press -> fail=1 after 16 cycles in WAIT_IN; without macro, still WAIT_IN after 10000 cycles.
